// File: rtl/sram_cmd_ctrl_if.sv
// Request/response bundle between a command requester and sram_cmd_ctrl.
// The master modport is the requester side; the slave modport is the controller.
interface sram_cmd_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              err_inject;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              rsp_perr;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, err_inject,
    input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_perr
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, err_inject,
    output req_ready, rsp_valid, rsp_data, rsp_last, rsp_perr
  );
endinterface

// File: rtl/sram_cmd_ctrl.sv
// Flop-based SRAM with single read/write, wrapping burst read and a clear sweep.
// Optional per-word even parity is enabled by defining SRAM_PARITY_EN.
module sram_cmd_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  sram_cmd_ctrl_if.slave   bus,
  output logic             busy
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_BURST = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {IDLE, BURST, CLEAR} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic [CNT_W-1:0]  cnt, cnt_next;

  logic              accept;
  logic              beat;
  logic              beat_last;
  logic [ADDR_W-1:0] beat_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_last_q;
  logic              rsp_perr_q;

`ifdef SRAM_PARITY_EN
  logic              mem_par [DEPTH];
  logic              mem_wpar;
`else
  logic              unused_err;
  assign unused_err = bus.err_inject;
`endif

  assign busy          = (state != IDLE);
  assign bus.req_ready = !busy;
  assign accept        = bus.req_valid && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    cnt_next   = cnt;
    beat       = 1'b0;
    beat_last  = 1'b0;
    beat_addr  = ptr;
    mem_we     = 1'b0;
    mem_waddr  = ptr;
    mem_wdata  = '0;
`ifdef SRAM_PARITY_EN
    mem_wpar   = 1'b0;
`endif
    case (state)
      CLEAR: begin
        mem_we   = 1'b1;
        ptr_next = ptr + ADDR_W'(1);
        if (ptr == LAST_ADDR) state_next = IDLE;
      end
      BURST: begin
        beat     = 1'b1;
        ptr_next = ptr + ADDR_W'(1);
        if (cnt == LAST_CNT) begin
          beat_last  = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        if (accept) begin
          case (bus.req_op)
            OP_READ: begin
              beat      = 1'b1;
              beat_last = 1'b1;
              beat_addr = bus.req_addr;
            end
            OP_WRITE: begin
              mem_we    = 1'b1;
              mem_waddr = bus.req_addr;
              mem_wdata = bus.req_wdata;
`ifdef SRAM_PARITY_EN
              mem_wpar  = (^bus.req_wdata) ^ bus.err_inject;
`endif
            end
            OP_BURST: begin
              beat      = 1'b1;
              beat_addr = bus.req_addr;
              ptr_next  = bus.req_addr + ADDR_W'(1);
              cnt_next  = CNT_W'(1);
              if (BURST_LEN == 1) beat_last = 1'b1;
              else                state_next = BURST;
            end
            OP_CLEAR: begin
              ptr_next   = '0;
              state_next = CLEAR;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // Storage is deliberately unreset; its contents are defined by the clear sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
`ifdef SRAM_PARITY_EN
      mem_par[mem_waddr] <= mem_wpar;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_perr_q  <= 1'b0;
    end else begin
      rsp_valid_q <= beat;
      rsp_last_q  <= beat_last;
      if (beat) rsp_data_q <= mem[beat_addr];
`ifdef SRAM_PARITY_EN
      rsp_perr_q  <= beat && ((^mem[beat_addr]) != mem_par[beat_addr]);
`else
      rsp_perr_q  <= 1'b0;
`endif
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_perr  = rsp_perr_q;
endmodule

// File: doc/sram_cmd_ctrl.md
Name: sram_cmd_ctrl

Overview:
Parametrised, flop-based SRAM with a request/response command interface.
Sits behind the tt_um_awenneb_sram top-level pin wrapper, which serialises commands from ui_in/uio_in and returns read data on uo_out.
Adds the following modes:
- single read and single write;
- auto-incrementing burst read with address wrap;
- whole-array clear, run automatically after reset and on command.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
BURST_LEN, 4, words returned per burst read; legal range 1..DEPTH

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  controller can accept a request; equals !busy
req_op  in  2  00 read, 01 write, 10 burst read, 11 clear-all
req_addr  in  ADDR_W  start or target address
req_wdata  in  DATA_W  write data
err_inject  in  1  flip the stored parity bit on this write (optional feature only)
rsp_valid  out  1  rsp_data valid this cycle; no backpressure
rsp_data  out  DATA_W  read data
rsp_last  out  1  final beat of a read or burst
rsp_perr  out  1  parity mismatch on this beat
busy  out  1  state != IDLE

Behaviour:
- Reset value of every output: rsp_valid=0, rsp_data=0, rsp_last=0, rsp_perr=0.
- While rst is asserted, state is forced to CLEAR with ptr=0, so busy=1 and req_ready=0.
- Memory array has no reset; it is defined only through the CLEAR sweep.
- FSM states are IDLE, BURST and CLEAR. A request is accepted when req_valid & req_ready at a rising edge.
- CLEAR: writes 0 to mem[ptr] each cycle, ptr increments, for exactly DEPTH cycles. Goes to IDLE on the edge that writes DEPTH-1.
- Write, IDLE: mem[req_addr] <= req_wdata at the accept edge. Stays in IDLE; back-to-back writes run every cycle.
- Read, IDLE: at the accept edge, rsp_data <= mem[req_addr] and rsp_valid <= 1, rsp_last <= 1. Latency is 1 cycle and back-to-back reads run every cycle.
- A write followed by a read of the same address on the next cycle returns the new data.
- Burst, IDLE: at the accept edge, the first beat loads mem[req_addr] with rsp_valid=1, then ptr <= addr+1 and cnt <= 1.
  - If BURST_LEN==1, rsp_last=1 and state stays IDLE. Otherwise state goes to BURST.
  - In BURST, each edge loads rsp_data <= mem[ptr], increments ptr modulo DEPTH, and increments cnt.
  - When cnt==BURST_LEN-1, rsp_last <= 1 and state goes to IDLE.
  - Beats are consecutive with no gaps. req_ready is low for BURST_LEN-1 cycles and is high again in the cycle the last beat is presented.
- Clear-all, IDLE: enters CLEAR with ptr=0. Behaviour is identical to the post-reset sweep.
- rsp_valid/rsp_last drop to 0 on any edge without a new beat. rsp_data holds its last value.
- Address wrap: ptr wraps modulo DEPTH, e.g. DEPTH-1 -> 0.
- Reset mid-burst or mid-clear: the operation is aborted immediately (asynchronous). Response outputs return to 0 and the clear sweep restarts from 0 after rst deasserts.
- Requests presented while busy are ignored. The requester holds them until req_ready is high.

Optional Feature:
Macro SRAM_PARITY_EN.
- Defined: each word stores an extra even-parity bit, computed on write as ^wdata ^ err_inject. CLEAR stores parity 0.
  - Every read beat sets rsp_perr = (^data != stored bit), in the same cycle as rsp_valid.
- Undefined: no parity storage, rsp_perr is tied 0 and err_inject is ignored.
- The port list is identical in both builds.

Test Plan:
1. Release rst -> busy=1 and req_ready=0 for exactly 16 cycles. Then a read of addr 5 gives rsp_valid=1, rsp_data=0x00, rsp_last=1 one cycle after accept.
2. Write 0xA5 to addr 3, then read addr 3 on the next cycle -> rsp_data=0xA5 one cycle after the read accept. Back-to-back reads of 3 and 4 give two consecutive valid beats.
3. Write 0x11, 0x22, 0x33, 0x44 to addrs 14, 15, 0, 1, then burst from 14 -> four consecutive beats 0x11, 0x22, 0x33, 0x44. rsp_last only on the 4th beat; req_ready low for 3 cycles.
4. After test 3, issue clear-all -> busy high 16 cycles, then reads of 14, 15, 0, 1 all return 0x00.
5. Assert rst after the 2nd beat of a burst -> rsp_valid=0 and rsp_last=0 immediately. On release, busy is high for 16 cycles and a read of addr 14 returns 0x00.
6. SRAM_PARITY_EN: write 0x01 to addr 2 with err_inject=1, and 0x03 to addr 6 without -> read 2 gives rsp_perr=1, read 6 gives rsp_perr=0. Without the macro, rsp_perr=0 always.
